// File: rtl/cla_serial_adder.sv
// Nibble-serial adder: one 4-bit carry-lookahead stage reused over WIDTH/4 cycles.
// Optional signed-overflow output is enabled by defining CLA_OVF_EN.
module cla_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [IDX_W-1:0] idx_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] a_sh_s;
    logic [WIDTH-1:0] b_sh_s;
    logic [3:0]       an_s;
    logic [3:0]       bn_s;
    logic [4:0]       res_s;
`ifdef CLA_OVF_EN
    logic             ovf_r;
`endif

    // Flat two-level lookahead: every carry is a direct sum of products, no ripple.
    // Returns {C4, nibble_sum}.
    function automatic logic [4:0] cla4(input logic [3:0] an, input logic [3:0] bn,
                                        input logic c);
        logic [3:0] p;
        logic [3:0] g;
        logic       c1;
        logic       c2;
        logic       c3;
        logic       c4;
        p  = an ^ bn;
        g  = an & bn;
        c1 = g[0] | (p[0] & c);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c);
        return {c4, p ^ {c3, c2, c1, c}};
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) next_state_s = ST_RUN;
                else          next_state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (idx_r == LAST_IDX) next_state_s = ST_DONE;
                else                   next_state_s = ST_RUN;
            end
            ST_DONE: begin
                if (out_ready) next_state_s = ST_IDLE;
                else           next_state_s = ST_DONE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Select the active nibble of each captured operand and run the lookahead stage.
    always_comb begin
        a_sh_s = a_r >> {idx_r, 2'b00};
        b_sh_s = b_r >> {idx_r, 2'b00};
        an_s   = a_sh_s[3:0];
        bn_s   = b_sh_s[3:0];
        res_s  = cla4(an_s, bn_s, carry_r);
    end

    // Operand capture, per-nibble sum write-back and result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r       <= {IDX_W{1'b0}};
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            sum_r       <= {WIDTH{1'b0}};
            cout_r      <= 1'b0;
            out_valid_r <= 1'b0;
`ifdef CLA_OVF_EN
            ovf_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        idx_r   <= {IDX_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    sum_r[{idx_r, 2'b00} +: 4] <= res_s[3:0];
                    carry_r                    <= res_s[4];
                    idx_r                      <= idx_r + IDX_W'(1);
                    if (idx_r == LAST_IDX) begin
                        cout_r      <= res_s[4];
                        out_valid_r <= 1'b1;
`ifdef CLA_OVF_EN
                        // Carry into the MSB is recovered from the MSB sum bit.
                        ovf_r       <= res_s[3] ^ an_s[3] ^ bn_s[3] ^ res_s[4];
`endif
                    end
                end
                ST_DONE: begin
                    if (out_ready) out_valid_r <= 1'b0;
                end
                default: out_valid_r <= 1'b0;
            endcase
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
`ifdef CLA_OVF_EN
    assign ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_cla_serial_adder.sv
// Self-checking bench for cla_serial_adder: directed cases plus random operands
// checked against plain integer addition. Build with CLA_OVF_EN to check ovf.
module tb_cla_serial_adder;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    logic         v4;
    logic         r4;
    logic [3:0]   a4;
    logic [3:0]   b4;
    logic         c4in;
    logic         ov4;
    logic         or4;
    logic [3:0]   s4;
    logic         co4;
    logic         ovf4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cla_serial_adder #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
`ifdef CLA_OVF_EN
        , .ovf(ovf)
`endif
    );

    cla_serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4),
        .a(a4), .b(b4), .cin(c4in), .out_valid(ov4), .out_ready(or4),
        .sum(s4), .cout(co4)
`ifdef CLA_OVF_EN
        , .ovf(ovf4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One full transaction with bp cycles of backpressure in DONE.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input int bp);
        int         full;
        int         cyc;
        logic [W:0] exp_full;
        logic       exp_ovf;
        logic [W-1:0] held;
        full     = int'(ta) + int'(tb) + int'(tc);
        exp_full = full[W:0];
        exp_ovf  = (ta[W-1] == tb[W-1]) && (exp_full[W-1] != ta[W-1]);
        @(negedge clk);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        check("in_ready_run", {31'd0, in_ready}, 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, N);
        check("sum", {16'd0, sum}, {16'd0, exp_full[W-1:0]});
        check("cout", {31'd0, cout}, {31'd0, exp_full[W]});
`ifdef CLA_OVF_EN
        check("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
`endif
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
            @(posedge clk); #1;
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_sum", {16'd0, sum}, {16'd0, exp_full[W-1:0]});
            check("bp_cout", {31'd0, cout}, {31'd0, exp_full[W]});
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hs_valid", {31'd0, out_valid}, 32'd0);
        check("hs_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        v4 = 1'b0; or4 = 1'b0; a4 = 4'h0; b4 = 4'h0; c4in = 1'b0;
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
`ifdef CLA_OVF_EN
        check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        @(negedge clk); rst_n = 1'b1;

        do_op(16'hFFFF, 16'h0001, 1'b0, 0);
        do_op(16'h1234, 16'h4321, 1'b1, 0);
        do_op(16'hA5A5, 16'h5A5B, 1'b0, 5);
        do_op(16'h7FFF, 16'h0001, 1'b0, 0);
        do_op(16'h8000, 16'h8000, 1'b0, 1);

        // Reset asserted while the third nibble is pending.
        @(negedge clk);
        a = 16'hBEEF; b = 16'h1357; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_sum", {16'd0, sum}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("abort_no_valid", {31'd0, out_valid}, 32'd0);
        end
        do_op(16'h00FF, 16'h0001, 1'b0, 0);

        for (int i = 0; i < 16; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        // Single-nibble instance.
        @(negedge clk);
        check("w4_in_ready", {31'd0, r4}, 32'd1);
        a4 = 4'hF; b4 = 4'h1; c4in = 1'b1; v4 = 1'b1;
        @(posedge clk); #1; v4 = 1'b0;
        cyc = 0;
        while (!ov4 && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("w4_latency", cyc, 1);
        check("w4_sum", {28'd0, s4}, 32'h1);
        check("w4_cout", {31'd0, co4}, 32'd1);
`ifdef CLA_OVF_EN
        check("w4_ovf", {31'd0, ovf4}, 32'd0);
`endif
        @(negedge clk); or4 = 1'b1;
        @(posedge clk); #1; or4 = 1'b0;
        check("w4_hs_valid", {31'd0, ov4}, 32'd0);
        check("w4_hs_ready", {31'd0, r4}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
